// File: rtl/vector_add_2_pkg.sv
// Shared constants for the VectorAdd_2 arbiter slice: operand/result field
// layout, default requester count and an index-width helper.
package vector_add_2_pkg;

   localparam int unsigned OPND_W = 10;
   localparam int unsigned RES_W  = 11;

   localparam int unsigned OFF_A0 = 30;
   localparam int unsigned OFF_A1 = 20;
   localparam int unsigned OFF_B0 = 10;
   localparam int unsigned OFF_B1 = 0;

   localparam int unsigned OFF_S0 = 11;
   localparam int unsigned OFF_S1 = 0;

   localparam int unsigned DEFAULT_NUM_REQ = 4;

   // clog2 with a floor of 1 so a 1-entry structure still gets a real index bit
   function automatic int unsigned idx_w(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((32'd1 << k) < n) w = k + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_tag_fifo.sv
// In-order tag FIFO recording which requester owns each operation in the core.
// Depth need not be a power of two; pointers wrap explicitly.
module rr_tag_fifo
   import vector_add_2_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_NUM_REQ,
   parameter int unsigned TAG_W = idx_w(DEFAULT_NUM_REQ),
   parameter int unsigned CNT_W = idx_w(DEFAULT_NUM_REQ + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [TAG_W-1:0] i_push_tag,
   input  logic             i_pop,
   output logic [TAG_W-1:0] o_head_tag,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int unsigned PTR_W = idx_w(DEPTH);

   logic [TAG_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_tag;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (w_do_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_tag = r_mem[r_rd_ptr];
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/vector_add_2_arbiter.sv
// Round-robin sharing of one VectorAdd_2 core among NUM_REQ requesters; an
// in-order tag FIFO routes each core result back to the requester that issued it.
module vector_add_2_arbiter
   import vector_add_2_pkg::*;
#(
   parameter int unsigned NUM_REQ         = DEFAULT_NUM_REQ,
   parameter int unsigned IDX_W           = idx_w(NUM_REQ),
   parameter int unsigned IN_DATA_LENGHT  = 4 * OPND_W,
   parameter int unsigned OUT_DATA_LENGHT = 2 * RES_W
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*IN_DATA_LENGHT-1:0]  req_data,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   input  logic [NUM_REQ-1:0]                 rsp_ready,
   output logic [NUM_REQ*OUT_DATA_LENGHT-1:0] rsp_data,
   output logic                               core_enable,
   output logic                               core_in_ready,
   output logic [IN_DATA_LENGHT-1:0]          core_in_data,
   input  logic                               core_out_ready,
   input  logic [OUT_DATA_LENGHT-1:0]         core_out_data,
   output logic                               err_orphan
);

   localparam int unsigned CNT_W = idx_w(NUM_REQ + 1);

   logic [NUM_REQ-1:0]                 r_inflight;
   logic [NUM_REQ-1:0]                 r_rsp_valid;
   logic [NUM_REQ*OUT_DATA_LENGHT-1:0] r_rsp_data;
   logic [IDX_W-1:0]                   r_rr_ptr;
   logic                               r_core_in_ready;
   logic [IN_DATA_LENGHT-1:0]          r_core_in_data;
   logic                               r_err_orphan;

   logic [NUM_REQ-1:0] w_busy;
   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_grant_mask;
   logic [NUM_REQ-1:0] w_done_mask;
   logic [IDX_W-1:0]   w_scan_idx;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_grant_any;
   logic [IDX_W-1:0]   w_fifo_head;
   logic               w_fifo_empty;
   logic [CNT_W-1:0]   w_fifo_count;
   logic               w_pop;
   logic               w_orphan;

   assign w_busy = r_inflight | r_rsp_valid;
   assign w_elig = {NUM_REQ{enable & ~reset}} & req_valid & ~w_busy;

   // first eligible index starting at the round-robin pointer
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_scan_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_scan_idx = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_grant_any && w_elig[w_scan_idx]) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_scan_idx;
         end
      end
   end

   always_comb begin
      w_grant_mask = '0;
      if (w_grant_any) w_grant_mask[w_grant_idx] = 1'b1;
   end

   assign w_pop    = core_out_ready & ~w_fifo_empty;
   assign w_orphan = core_out_ready & (w_fifo_count == '0);

   always_comb begin
      w_done_mask = '0;
      if (w_pop) w_done_mask[w_fifo_head] = 1'b1;
   end

   rr_tag_fifo #(
      .DEPTH (NUM_REQ),
      .TAG_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_grant_any),
      .i_push_tag (w_grant_idx),
      .i_pop      (w_pop),
      .o_head_tag (w_fifo_head),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight      <= '0;
         r_rsp_valid     <= '0;
         r_rsp_data      <= '0;
         r_rr_ptr        <= '0;
         r_core_in_ready <= 1'b0;
         r_core_in_data  <= '0;
         r_err_orphan    <= 1'b0;
      end else begin
         r_core_in_ready <= w_grant_any;
         if (w_grant_any) begin
            r_core_in_data <= req_data[w_grant_idx*IN_DATA_LENGHT +: IN_DATA_LENGHT];
            r_rr_ptr       <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
         end
         // a grant and a completion never target the same requester, so set/clear commute
         r_inflight  <= (r_inflight & ~w_done_mask) | w_grant_mask;
         r_rsp_valid <= (r_rsp_valid & ~rsp_ready) | w_done_mask;
         if (w_pop) r_rsp_data[w_fifo_head*OUT_DATA_LENGHT +: OUT_DATA_LENGHT] <= core_out_data;
         if (w_orphan) r_err_orphan <= 1'b1;
      end
   end

   assign req_ready     = w_grant_mask;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign core_enable   = enable;
   assign core_in_ready = r_core_in_ready;
   assign core_in_data  = r_core_in_data;
   assign err_orphan    = r_err_orphan;

endmodule

// File: tb/tb_vector_add_2_arbiter.sv
// Scoreboard bench for vector_add_2_arbiter with a behavioural adder-core model.
module tb_vector_add_2_arbiter;
   import vector_add_2_pkg::*;

   localparam int N  = 4;
   localparam int DI = 40;
   localparam int DO = 22;

   logic            clk;
   logic            reset;
   logic            enable;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DI-1:0] req_data;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [N*DO-1:0] rsp_data;
   logic            core_enable;
   logic            core_in_ready;
   logic [DI-1:0]   core_in_data;
   logic            core_out_ready;
   logic [DO-1:0]   core_out_data;
   logic            err_orphan;

   vector_add_2_arbiter #(
      .NUM_REQ         (N),
      .IDX_W           (2),
      .IN_DATA_LENGHT  (DI),
      .OUT_DATA_LENGHT (DO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_data       (req_data),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .core_enable    (core_enable),
      .core_in_ready  (core_in_ready),
      .core_in_data   (core_in_data),
      .core_out_ready (core_out_ready),
      .core_out_data  (core_out_data),
      .err_orphan     (err_orphan)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {S0,S1} = {A0+B0, A1+B1}, computed as plain integers
   function automatic logic [DO-1:0] add_ref(input logic [DI-1:0] op);
      int unsigned s0, s1;
      s0 = 32'(op[OFF_A0 +: OPND_W]) + 32'(op[OFF_B0 +: OPND_W]);
      s1 = 32'(op[OFF_A1 +: OPND_W]) + 32'(op[OFF_B1 +: OPND_W]);
      return DO'(s0 * 2048 + s1);
   endfunction

   // ---------------- reference model / scoreboard (monitor-owned) ----------------
   typedef struct {
      int            owner;
      logic [DO-1:0] sum;
   } tag_t;

   tag_t          sb_q[$];
   logic [DI-1:0] cin_q[$];
   bit            m_busy[N];
   bit            m_rspv[N];
   logic [DO-1:0] m_rdat[N];
   int            m_ptr = 0;
   bit            m_err = 0;
   bit            mon_en = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (reset) begin
            chk("req_ready_in_reset", 64'(req_ready), 64'd0);
            sb_q.delete();
            cin_q.delete();
            for (int i = 0; i < N; i++) begin
               m_busy[i] = 0;
               m_rspv[i] = 0;
            end
            m_ptr = 0;
            m_err = 0;
         end else begin
            int           g;
            int           idx;
            logic [N-1:0] exp_rdy;
            logic [N-1:0] exp_v;
            tag_t         t;
            logic [DI-1:0] op;

            chk("err_orphan", 64'(err_orphan), 64'(m_err));
            chk("core_enable", 64'(core_enable), 64'(enable));
            if (cin_q.size() > 0) begin
               chk("core_in_ready", 64'(core_in_ready), 64'd1);
               chk("core_in_data", 64'(core_in_data), 64'(cin_q.pop_front()));
            end else begin
               chk("core_in_ready_idle", 64'(core_in_ready), 64'd0);
            end

            for (int i = 0; i < N; i++) exp_v[i] = m_rspv[i];
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            for (int i = 0; i < N; i++) begin
               if (m_rspv[i] && rsp_valid[i])
                  chk($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DO +: DO]), 64'(m_rdat[i]));
            end

            g = -1;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (g < 0 && enable && req_valid[idx] && !m_busy[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));

            for (int i = 0; i < N; i++) begin
               if (m_rspv[i] && rsp_ready[i]) begin
                  m_rspv[i] = 0;
                  m_busy[i] = 0;
               end
            end
            if (core_out_ready) begin
               if (sb_q.size() > 0) begin
                  t = sb_q.pop_front();
                  m_rspv[t.owner] = 1;
                  m_rdat[t.owner] = t.sum;
               end else begin
                  m_err = 1;
               end
            end
            if (g >= 0) begin
               op      = req_data[g*DI +: DI];
               t.owner = g;
               t.sum   = add_ref(op);
               sb_q.push_back(t);
               cin_q.push_back(op);
               m_busy[g] = 1;
               m_ptr     = (g + 1) % N;
            end
         end
      end
   end

   // ---------------- stimulus and adder-core model ----------------
   typedef struct {
      logic [DO-1:0] d;
      int            cnt;
   } pipe_t;

   pipe_t        pipe_q[$];
   logic [N-1:0] acc;
   bit           en_prev = 0;
   bit           auto_req = 0;
   bit           en_rand = 0;
   bit           orphan_req = 0;
   int           rsp_mode = 1;
   int           lat_lo = 1;
   int           lat_hi = 4;

   function automatic logic [DI-1:0] rand_op();
      return DI'({$urandom, $urandom});
   endfunction

   task automatic set_req(input int i, input logic [DI-1:0] op);
      req_valid[i]          = 1'b1;
      req_data[i*DI +: DI]  = op;
   endtask

   task automatic step();
      pipe_t p;
      @(negedge clk);
      acc     = req_valid & req_ready;
      en_prev = enable;
      @(posedge clk);
      #1;
      core_out_ready = 1'b0;
      if (reset) begin
         pipe_q.delete();
      end else begin
         if (en_prev) begin
            foreach (pipe_q[j]) pipe_q[j].cnt--;
         end
         if (pipe_q.size() > 0 && pipe_q[0].cnt <= 0) begin
            core_out_ready = 1'b1;
            core_out_data  = pipe_q[0].d;
            void'(pipe_q.pop_front());
         end else if (orphan_req) begin
            core_out_ready = 1'b1;
            core_out_data  = DO'($urandom);
            orphan_req     = 0;
         end
         if (core_in_ready) begin
            p.d   = add_ref(core_in_data);
            p.cnt = $urandom_range(lat_hi, lat_lo);
            pipe_q.push_back(p);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i]) req_valid[i] = 1'b0;
         if (auto_req && !req_valid[i] && $urandom_range(3, 0) == 0) set_req(i, rand_op());
      end
      case (rsp_mode)
         0:       rsp_ready = N'($urandom);
         1:       rsp_ready = '1;
         default: rsp_ready = '0;
      endcase
      if (en_rand && $urandom_range(9, 0) == 0) enable = ~enable;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      int c;
      reset          = 1'b1;
      enable         = 1'b0;
      req_valid      = '0;
      req_data       = '0;
      rsp_ready      = '0;
      core_out_ready = 1'b0;
      core_out_data  = '0;

      @(posedge clk);
      #1;
      chk("reset_core_in_ready", 64'(core_in_ready), 64'd0);
      chk("reset_core_in_data", 64'(core_in_data), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_data", 64'(rsp_data), 64'd0);
      chk("reset_err_orphan", 64'(err_orphan), 64'd0);
      mon_en = 1;
      step();
      reset  = 1'b0;
      enable = 1'b1;

      // single request from requester 1
      rsp_mode = 2;
      set_req(1, {10'd1, 10'd2, 10'd3, 10'd4});
      for (c = 0; c < 30 && rsp_valid[1] !== 1'b1; c++) step();
      chk("single_rsp_valid", 64'(rsp_valid), 64'h2);
      chk("single_rsp_data", 64'(rsp_data[DO +: DO]), 64'h002006);
      rsp_mode = 1;
      repeat (3) step();

      // contention straight out of reset: grants 0,1,2,3
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, {10'(i), 10'(i), 10'(i), 10'(i)});
      for (int k = 0; k < N; k++) begin
         step();
         chk($sformatf("contention_grant_%0d", k), 64'(acc), 64'(1 << k));
      end
      repeat (15) step();

      // randomized traffic with back-pressure and enable gaps
      auto_req = 1;
      rsp_mode = 0;
      en_rand  = 1;
      lat_hi   = 6;
      repeat (3000) step();

      // enable low with two operations in flight
      auto_req = 0;
      en_rand  = 0;
      enable   = 1'b1;
      rsp_mode = 1;
      for (c = 0; c < 200 && (sb_q.size() != 0 || req_valid != '0 || pipe_q.size() != 0); c++) step();
      chk("drain_before_enable_test", 64'(sb_q.size()), 64'd0);
      lat_lo = 8;
      lat_hi = 8;
      set_req(0, rand_op());
      set_req(3, rand_op());
      repeat (2) step();
      enable = 1'b0;
      set_req(1, rand_op());
      repeat (10) step();
      chk("disabled_core_enable", 64'(core_enable), 64'd0);
      chk("disabled_req_ready", 64'(req_ready), 64'd0);
      enable = 1'b1;
      lat_lo = 1;
      lat_hi = 4;
      repeat (30) step();

      // orphan completion
      for (c = 0; c < 200 && (sb_q.size() != 0 || req_valid != '0 || pipe_q.size() != 0 || rsp_valid != '0); c++) step();
      chk("drain_before_orphan", 64'(sb_q.size()), 64'd0);
      orphan_req = 1;
      repeat (2) step();
      chk("orphan_set", 64'(err_orphan), 64'd1);
      repeat (5) step();
      chk("orphan_sticky", 64'(err_orphan), 64'd1);

      // reset with three operations in flight
      rsp_mode = 2;
      lat_lo   = 30;
      lat_hi   = 30;
      set_req(0, rand_op());
      set_req(1, rand_op());
      set_req(2, rand_op());
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midop_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midop_reset_err_orphan", 64'(err_orphan), 64'd0);
      chk("midop_reset_core_in_ready", 64'(core_in_ready), 64'd0);
      rsp_mode = 1;
      lat_lo   = 1;
      lat_hi   = 4;
      repeat (40) step();
      for (int i = 0; i < N; i++) set_req(i, rand_op());
      step();
      chk("post_reset_first_grant", 64'(acc), 64'd1);
      repeat (25) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
